wb_arbiter_n: RTL

- N-master to 1-slave pipelined Wishbone B4 arbiter; successor to the 2-master arbiter.
- Supports a parametrised master count and round-robin or fixed-priority selection.
- Counts outstanding transactions and throttles the owner once a limit is reached.
- Sits between CPU/DMA/debug masters and a shared crossbar or memory port.

---
 rtl/wb_arbiter_n_if.sv | 41 ++++
 rtl/wb_arbiter_n.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_n_if.sv
// Signal bundle for wb_arbiter_n: NM pipelined Wishbone B4 masters plus the shared slave port.
interface wb_arbiter_n_if #(
    parameter int NM = 4,
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [NM-1:0]      i_m_cyc;
    logic [NM-1:0]      i_m_stb;
    logic [NM-1:0]      i_m_we;
    logic [NM*AW-1:0]   i_m_adr;
    logic [NM*DW-1:0]   i_m_dat;
    logic [NM*DW/8-1:0] i_m_sel;
    logic [NM-1:0]      o_m_ack;
    logic [NM-1:0]      o_m_stall;
    logic [NM-1:0]      o_m_err;
    logic               o_cyc;
    logic               o_stb;
    logic               o_we;
    logic [AW-1:0]      o_adr;
    logic [DW-1:0]      o_dat;
    logic [DW/8-1:0]    o_sel;
    logic               i_ack;
    logic               i_stall;
    logic               i_err;

    // The arbiter: it serves the masters and drives the shared slave port.
    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
        output o_m_ack, o_m_stall, o_m_err,
        output o_cyc, o_stb, o_we, o_adr, o_dat, o_sel,
        input  i_ack, i_stall, i_err
    );

    // The surroundings: requesting masters and the downstream slave.
    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
        input  o_m_ack, o_m_stall, o_m_err,
        input  o_cyc, o_stb, o_we, o_adr, o_dat, o_sel,
        output i_ack, i_stall, i_err
    );
endinterface

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave pipelined Wishbone B4 arbiter with outstanding-transaction throttling.
// Optional slave watchdog is enabled by defining WBARB_TIMEOUT_EN.
module wb_arbiter_n #(
    parameter int    NM       = 4,
    parameter int    DW       = 32,
    parameter int    AW       = 32,
    parameter string SCHEME   = "ROUND_ROBIN",
    parameter int    LGMAXOUT = 3,
    parameter int    TIMEOUT  = 255
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    wb_arbiter_n_if.slave bus
);
    localparam int RW       = (NM > 1) ? $clog2(NM) : 1;
    localparam bit USE_PRIO = (SCHEME == "PRIORITY");

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t              state_r;
    logic [NM-1:0]       grant_r;
    logic [RW-1:0]       rr_r;
    logic [LGMAXOUT-1:0] count_r;

    logic [NM-1:0]       req_s;
    logic [NM-1:0]       cand_s;
    logic                rearb_s;
    logic                win_found_s;
    logic [RW-1:0]       win_idx_s;
    logic [RW:0]         scan_s;
    logic                owner_cyc_s;
    logic                owner_stb_s;
    logic                owner_we_s;
    logic [AW-1:0]       adr_s;
    logic [DW-1:0]       dat_s;
    logic [DW/8-1:0]     sel_s;
    logic                full_s;
    logic                cyc_s;
    logic                stb_s;
    logic                inc_s;
    logic                dec_s;
    logic                clr_s;
    logic                to_pulse_s;

    // Owner field mux: each master's fields are masked by its grant bit, so IDLE yields zeros.
    always_comb begin
        owner_cyc_s = |(bus.i_m_cyc & grant_r);
        owner_stb_s = |(bus.i_m_stb & grant_r);
        owner_we_s  = 1'b0;
        adr_s       = '0;
        dat_s       = '0;
        sel_s       = '0;
        for (int k = 0; k < NM; k++) begin
            owner_we_s = owner_we_s | (bus.i_m_we[k] & grant_r[k]);
            adr_s      = adr_s | (bus.i_m_adr[k*AW +: AW] & {AW{grant_r[k]}});
            dat_s      = dat_s | (bus.i_m_dat[k*DW +: DW] & {DW{grant_r[k]}});
            sel_s      = sel_s | (bus.i_m_sel[k*(DW/8) +: (DW/8)] & {(DW/8){grant_r[k]}});
        end
    end

    // Winner selection among requesters other than the departing owner.
    always_comb begin
        req_s       = bus.i_m_cyc & bus.i_m_stb;
        rearb_s     = (state_r == ST_IDLE) || !owner_cyc_s;
        cand_s      = rearb_s ? (req_s & ~grant_r) : {NM{1'b0}};
        win_idx_s   = '0;
        win_found_s = 1'b0;
        scan_s      = '0;
        if (USE_PRIO) begin
            for (int k = NM - 1; k >= 0; k--) begin
                win_idx_s = cand_s[k] ? RW'(k) : win_idx_s;
            end
        end else begin
            for (int i = 1; i <= NM; i++) begin
                scan_s      = {1'b0, rr_r} + (RW+1)'(i);
                scan_s      = (scan_s >= (RW+1)'(NM)) ? scan_s - (RW+1)'(NM) : scan_s;
                win_idx_s   = (cand_s[scan_s[RW-1:0]] && !win_found_s) ? scan_s[RW-1:0] : win_idx_s;
                win_found_s = win_found_s | cand_s[scan_s[RW-1:0]];
            end
        end
        win_found_s = |cand_s;
    end

    assign full_s = (count_r == {LGMAXOUT{1'b1}});
    assign cyc_s  = owner_cyc_s & ~to_pulse_s;
    assign stb_s  = owner_stb_s & ~full_s & ~to_pulse_s;
    assign inc_s  = stb_s & ~bus.i_stall;
    assign dec_s  = bus.i_ack | bus.i_err;
    assign clr_s  = bus.i_err | to_pulse_s | ((state_r == ST_OWNED) & ~owner_cyc_s);

    // Ownership FSM: hand the bus over on the edge where the owner drops cyc, with no dead cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            rr_r    <= RW'(NM - 1);
        end else if (rearb_s) begin
            if (win_found_s) begin
                state_r <= ST_OWNED;
                grant_r <= {{(NM-1){1'b0}}, 1'b1} << win_idx_s;
                rr_r    <= win_idx_s;
            end else begin
                state_r <= ST_IDLE;
                grant_r <= '0;
                rr_r    <= rr_r;
            end
        end else begin
            state_r <= state_r;
            grant_r <= grant_r;
            rr_r    <= rr_r;
        end
    end

    // Outstanding-request counter; saturates at both ends since stb is gated when full.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_r <= '0;
        end else if (clr_s) begin
            count_r <= '0;
        end else if (inc_s && !dec_s) begin
            count_r <= count_r + LGMAXOUT'(1);
        end else if (dec_s && !inc_s && (count_r != '0)) begin
            count_r <= count_r - LGMAXOUT'(1);
        end else begin
            count_r <= count_r;
        end
    end

`ifdef WBARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_r;
    logic           to_pulse_r;
    logic           wd_wait_s;
    logic           wd_kick_s;

    assign wd_wait_s = (state_r == ST_OWNED) && ((count_r != '0) || (stb_s && bus.i_stall));
    assign wd_kick_s = bus.i_ack | bus.i_err | inc_s;

    // Slave watchdog: a single-cycle abort pulse once the owner waited TIMEOUT cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_r       <= '0;
            to_pulse_r <= 1'b0;
        end else if (wd_kick_s || !wd_wait_s || to_pulse_r) begin
            wd_r       <= '0;
            to_pulse_r <= 1'b0;
        end else if (wd_r == WDW'(TIMEOUT - 1)) begin
            wd_r       <= '0;
            to_pulse_r <= 1'b1;
        end else begin
            wd_r       <= wd_r + WDW'(1);
            to_pulse_r <= 1'b0;
        end
    end

    assign to_pulse_s = to_pulse_r;
`else
    assign to_pulse_s = 1'b0;
`endif

    assign bus.o_cyc     = cyc_s;
    assign bus.o_stb     = stb_s;
    assign bus.o_we      = owner_we_s;
    assign bus.o_adr     = adr_s;
    assign bus.o_dat     = dat_s;
    assign bus.o_sel     = sel_s;
    assign bus.o_m_ack   = {NM{bus.i_ack & cyc_s}} & grant_r;
    assign bus.o_m_err   = ({NM{bus.i_err & cyc_s}} | {NM{to_pulse_s}}) & grant_r;
    assign bus.o_m_stall = ~grant_r | {NM{bus.i_stall | full_s}};
endmodule
